keypad_decoder: RTL

Downstream stage of the keypad column scanner. It consumes the scanner's one-cycle `sense` strobe together with the live `row` lines and the registered `col` drive, and converts the pressed position into a 4-bit key code. Codes go into a small FIFO and are presented to the consumer (display/entry logic) over a valid/ready handshake. Overflow is reported with a sticky flag.

---
 rtl/keypad_pkg.sv | 71 +++++++
 rtl/keypad_decoder_if.sv | 11 +
 rtl/keypad_fifo.sv | 84 ++++++++
 rtl/keypad_decoder.sv | 122 ++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, key code constants and index/keymap helpers for the keypad decoder.
package keypad_pkg;

   typedef logic [3:0] key_code_t;

   typedef struct packed {
      logic       ok;
      logic [1:0] idx;
   } onehot_t;

   localparam key_code_t KEY_0    = 4'h0;
   localparam key_code_t KEY_1    = 4'h1;
   localparam key_code_t KEY_2    = 4'h2;
   localparam key_code_t KEY_3    = 4'h3;
   localparam key_code_t KEY_4    = 4'h4;
   localparam key_code_t KEY_5    = 4'h5;
   localparam key_code_t KEY_6    = 4'h6;
   localparam key_code_t KEY_7    = 4'h7;
   localparam key_code_t KEY_8    = 4'h8;
   localparam key_code_t KEY_9    = 4'h9;
   localparam key_code_t KEY_A    = 4'hA;
   localparam key_code_t KEY_B    = 4'hB;
   localparam key_code_t KEY_C    = 4'hC;
   localparam key_code_t KEY_D    = 4'hD;
   localparam key_code_t KEY_STAR = 4'hE;
   localparam key_code_t KEY_HASH = 4'hF;

   // Lowest set bit wins; an all-zero vector resolves to index 0.
   function automatic logic [1:0] lowest_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (v[i]) begin
            idx = 2'(i);
         end
      end
      return idx;
   endfunction

   function automatic onehot_t onehot_idx(input logic [3:0] v);
      onehot_t res;
      res.idx = lowest_idx(v);
      res.ok  = $onehot(v);
      return res;
   endfunction

   function automatic key_code_t keymap(input logic [1:0] r, input logic [1:0] c);
      key_code_t code;
      case ({r, c})
         4'b00_00: code = KEY_1;
         4'b00_01: code = KEY_2;
         4'b00_10: code = KEY_3;
         4'b00_11: code = KEY_A;
         4'b01_00: code = KEY_4;
         4'b01_01: code = KEY_5;
         4'b01_10: code = KEY_6;
         4'b01_11: code = KEY_B;
         4'b10_00: code = KEY_7;
         4'b10_01: code = KEY_8;
         4'b10_10: code = KEY_9;
         4'b10_11: code = KEY_C;
         4'b11_00: code = KEY_STAR;
         4'b11_01: code = KEY_0;
         4'b11_10: code = KEY_HASH;
         4'b11_11: code = KEY_D;
         default:  code = KEY_0;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_decoder_if.sv
// Valid/ready key-code handshake between the decoder (master) and its consumer (slave).
interface keypad_decoder_if;
   import keypad_pkg::*;

   key_code_t key_code;
   logic      key_valid;
   logic      key_ready;

   modport master (output key_code, output key_valid, input key_ready);
   modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_fifo.sv
// Circular FIFO with registered head data, non-empty flag and occupancy count.
module keypad_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [CW-1:0]    r_count;
   logic             r_valid;
   logic [WIDTH-1:0] r_rdata;

   logic             w_pop;
   logic             w_push_ok;
   logic [AW-1:0]    w_rd_nxt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [WIDTH-1:0] w_head_nxt;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = !r_valid;
   assign o_count = r_count;
   assign o_rdata = r_rdata;

   // A full FIFO still accepts a push when the head is popped in the same cycle.
   always_comb begin
      w_pop     = i_pop && r_valid;
      w_push_ok = i_push && (!o_full || w_pop);
      w_rd_nxt  = w_pop ? (r_rd + AW'(1)) : r_rd;
      case ({w_push_ok, w_pop})
         2'b10:   w_cnt_nxt = r_count + CW'(1);
         2'b01:   w_cnt_nxt = r_count - CW'(1);
         default: w_cnt_nxt = r_count;
      endcase
      if (w_push_ok && (r_wr == w_rd_nxt)) begin
         w_head_nxt = i_wdata;
      end else begin
         w_head_nxt = r_mem[w_rd_nxt];
      end
   end

   // Pointers, occupancy and registered head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_valid <= 1'b0;
         r_rdata <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr <= r_wr + AW'(1);
         end
         r_rd    <= w_rd_nxt;
         r_count <= w_cnt_nxt;
         r_valid <= (w_cnt_nxt != CW'(0));
         r_rdata <= w_head_nxt;
      end
   end

   // Storage array.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push_ok) begin
         r_mem[r_wr] <= i_wdata;
      end
   end

endmodule

// File: rtl/keypad_decoder.sv
// Keypad capture/decode stage feeding a key-code FIFO with sticky overflow.
// Optional KEYPAD_ERR_EN: reject non-one-hot captures and pulse err instead.
module keypad_decoder
   import keypad_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [3:0]             row,
   input  logic [3:0]             col,
   input  logic                   sense,
   keypad_decoder_if.master       kif,
   output logic [$clog2(DEPTH):0] count,
   output logic                   ovf,
   input  logic                   ovf_clr
`ifdef KEYPAD_ERR_EN
   ,
   output logic                   err
`endif
);
   logic       r_arm;
   logic       r_sense_d;
   logic       r_cap_stb;
   logic [3:0] r_row;
   logic [3:0] r_col;
   logic       r_ovf;

   logic       w_cap;
   logic [1:0] w_row_idx;
   logic [1:0] w_col_idx;
   key_code_t  w_code;
   logic       w_push;
   logic       w_full;
   logic       w_empty;
   key_code_t  w_head;
   logic       w_pop;
   logic       w_drop;

   // r_arm blocks a capture in the first cycle after reset release.
   assign w_cap = sense && !r_sense_d && r_arm;

   // Strobe edge detect and capture register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_arm     <= 1'b0;
         r_sense_d <= 1'b0;
         r_cap_stb <= 1'b0;
         r_row     <= 4'b0000;
         r_col     <= 4'b0000;
      end else begin
         r_arm     <= 1'b1;
         r_sense_d <= sense;
         r_cap_stb <= w_cap;
         if (w_cap) begin
            r_row <= row;
            r_col <= col;
         end
      end
   end

`ifdef KEYPAD_ERR_EN
   onehot_t w_row_oh;
   onehot_t w_col_oh;
   logic    r_err;

   assign w_row_oh  = onehot_idx(r_row);
   assign w_col_oh  = onehot_idx(r_col);
   assign w_row_idx = w_row_oh.idx;
   assign w_col_idx = w_col_oh.idx;
   assign w_push    = r_cap_stb && w_row_oh.ok && w_col_oh.ok;
   assign err       = r_err;

   // One-cycle pulse for a rejected capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else begin
         r_err <= r_cap_stb && !(w_row_oh.ok && w_col_oh.ok);
      end
   end
`else
   assign w_row_idx = lowest_idx(r_row);
   assign w_col_idx = lowest_idx(r_col);
   assign w_push    = r_cap_stb;
`endif

   assign w_code = keymap(w_row_idx, w_col_idx);
   assign w_pop  = !w_empty && kif.key_ready;
   assign w_drop = w_push && w_full && !w_pop;

   keypad_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (4)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_wdata (w_code),
      .i_pop   (kif.key_ready),
      .o_rdata (w_head),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_count (count)
   );

   assign kif.key_code  = w_head;
   assign kif.key_valid = !w_empty;
   assign ovf           = r_ovf;

   // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

endmodule
